// File: rtl/mac_unit_bitcol_seq.sv
// Bit-column-serial MAC: one latched activation vector, one weight bit-column per beat,
// sparse window muxes per group, shifted accumulation and a saturated, scaled result.
module mac_unit_bitcol_seq #(
    parameter int DATA_WIDTH    = 8,
    parameter int VEC_LENGTH    = 32,
    parameter int GROUP_SIZE    = 8,
    parameter int MUX_SEL_WIDTH = 3,
    parameter int MAX_PREC      = 8,
    parameter int ACC_WIDTH     = DATA_WIDTH + 16,
    parameter int RESULT_WIDTH  = 2 * DATA_WIDTH,
    parameter int OUT_SHIFT     = 8
) (
    input  logic                                                         clk,
    input  logic                                                         reset,
    input  logic                                                         start,
    output logic                                                         start_ready,
    input  logic [VEC_LENGTH*DATA_WIDTH-1:0]                             act_in,
    input  logic [(VEC_LENGTH/GROUP_SIZE)*(DATA_WIDTH+$clog2(GROUP_SIZE))-1:0] sum_act,
    input  logic [ACC_WIDTH-1:0]                                         accum_init,
    input  logic [$clog2(MAX_PREC+1)-1:0]                                prec,
    input  logic                                                         signed_mode,
    input  logic                                                         col_valid,
    output logic                                                         col_ready,
    input  logic [$clog2(MAX_PREC)-1:0]                                  col_idx,
    input  logic                                                         col_last,
    input  logic [(VEC_LENGTH/2)*MUX_SEL_WIDTH-1:0]                      col_sel,
    input  logic [VEC_LENGTH/2-1:0]                                      col_val,
    input  logic [VEC_LENGTH/GROUP_SIZE-1:0]                             col_skip_zero,
    output logic                                                         out_valid,
    input  logic                                                         out_ready,
    output logic [RESULT_WIDTH-1:0]                                      result
);

    localparam int NG     = VEC_LENGTH / GROUP_SIZE;
    localparam int HALF   = GROUP_SIZE / 2;
    localparam int SUM_W  = DATA_WIDTH + $clog2(GROUP_SIZE);
    localparam int PREC_W = $clog2(MAX_PREC + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [MUX_SEL_WIDTH-1:0] SEL_MAX = MUX_SEL_WIDTH'(HALF);
    localparam logic signed [ACC_WIDTH-1:0] RES_MAX =
        {{(ACC_WIDTH-RESULT_WIDTH+1){1'b0}}, {(RESULT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] RES_MIN = ~RES_MAX;

    logic [1:0]                        state;
    logic [VEC_LENGTH*DATA_WIDTH-1:0]  act_q;
    logic [NG*SUM_W-1:0]               sum_act_q;
    logic [PREC_W-1:0]                 prec_q;
    logic                              signed_q;
    logic                              s1_valid;
    logic signed [ACC_WIDTH-1:0]       s1_data;
    logic signed [ACC_WIDTH-1:0]       acc;

    logic                              start_fire;
    logic                              beat_fire;
    logic                              negate;
    logic [MUX_SEL_WIDTH-1:0]          sel;
    logic signed [DATA_WIDTH-1:0]      a_el;
    logic signed [SUM_W-1:0]           sa_el;
    logic signed [ACC_WIDTH-1:0]       part;
    logic signed [ACC_WIDTH-1:0]       col_sum;
    logic signed [ACC_WIDTH-1:0]       col_term;
    logic signed [ACC_WIDTH-1:0]       acc_sh;
    logic [RESULT_WIDTH-1:0]           sat_val;

    assign start_ready = (state == ST_IDLE);
    assign col_ready   = (state == ST_RUN);
    assign start_fire  = start && start_ready;
    assign beat_fire   = col_valid && col_ready;

    // Slot j of a group sees a window act[j .. j+HALF]; selects above HALF read as zero.
    always_comb begin
        col_sum = '0;
        part    = '0;
        sel     = '0;
        a_el    = '0;
        sa_el   = '0;
        for (int unsigned g = 0; g < NG; g++) begin
            part = '0;
            for (int unsigned j = 0; j < HALF; j++) begin
                sel = col_sel[(g*HALF + j)*MUX_SEL_WIDTH +: MUX_SEL_WIDTH];
                if (col_val[g*HALF + j] && (sel <= SEL_MAX)) begin
                    a_el = act_q[(g*GROUP_SIZE + j + 32'(sel))*DATA_WIDTH +: DATA_WIDTH];
                    part = part + {{(ACC_WIDTH-DATA_WIDTH){a_el[DATA_WIDTH-1]}}, a_el};
                end
            end
            if (col_skip_zero[g]) begin
                col_sum = col_sum + part;
            end else begin
                sa_el   = sum_act_q[g*SUM_W +: SUM_W];
                col_sum = col_sum + {{(ACC_WIDTH-SUM_W){sa_el[SUM_W-1]}}, sa_el} - part;
            end
        end
    end

    assign negate   = signed_q && (PREC_W'(col_idx) == (prec_q - PREC_W'(1)));
    assign col_term = (negate ? -col_sum : col_sum) <<< col_idx;

    always_comb begin
        acc_sh = acc >>> OUT_SHIFT;
        if (acc_sh > RES_MAX) begin
            sat_val = RES_MAX[RESULT_WIDTH-1:0];
        end else if (acc_sh < RES_MIN) begin
            sat_val = RES_MIN[RESULT_WIDTH-1:0];
        end else begin
            sat_val = acc_sh[RESULT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            act_q     <= '0;
            sum_act_q <= '0;
            prec_q    <= '0;
            signed_q  <= 1'b0;
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            s1_valid <= beat_fire;
            if (beat_fire) begin
                s1_data <= col_term;
            end

            if (start_fire) begin
                acc <= accum_init;
            end else if (s1_valid) begin
                acc <= acc + s1_data;
            end

            case (state)
                ST_IDLE: begin
                    if (start_fire) begin
                        act_q     <= act_in;
                        sum_act_q <= sum_act;
                        prec_q    <= prec;
                        signed_q  <= signed_mode;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (beat_fire && col_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state <= ST_DONE;
                end
                default: begin
                    // Result is captured one edge after the final accumulate, then held.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        result    <= sat_val;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_unit_bitcol_seq.sv
// Scoreboard bench for mac_unit_bitcol_seq: two instances (OUT_SHIFT 0 and 8) share stimulus;
// the driver queues hand-computed accumulator values, the monitor checks both scaled results.
module tb_mac_unit_bitcol_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         start_ready, start_ready8;
    logic [255:0] act_in;
    logic [43:0]  sum_act;
    logic [23:0]  accum_init;
    logic [3:0]   prec;
    logic         signed_mode;
    logic         col_valid;
    logic         col_ready, col_ready8;
    logic [2:0]   col_idx;
    logic         col_last;
    logic [47:0]  col_sel;
    logic [15:0]  col_val;
    logic [3:0]   col_skip_zero;
    logic         out_valid, out_valid8;
    logic         out_ready;
    logic [15:0]  result, result8;

    int     checks = 0;
    int     errors = 0;
    int     hold_n = 0;
    longint exp_q[$];
    longint exp_acc;

    always #5 clk = ~clk;

    mac_unit_bitcol_seq #(.OUT_SHIFT(0)) u_dut (
        .clk(clk), .reset(reset), .start(start), .start_ready(start_ready),
        .act_in(act_in), .sum_act(sum_act), .accum_init(accum_init), .prec(prec),
        .signed_mode(signed_mode), .col_valid(col_valid), .col_ready(col_ready),
        .col_idx(col_idx), .col_last(col_last), .col_sel(col_sel), .col_val(col_val),
        .col_skip_zero(col_skip_zero), .out_valid(out_valid), .out_ready(out_ready),
        .result(result)
    );

    mac_unit_bitcol_seq #(.OUT_SHIFT(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start), .start_ready(start_ready8),
        .act_in(act_in), .sum_act(sum_act), .accum_init(accum_init), .prec(prec),
        .signed_mode(signed_mode), .col_valid(col_valid), .col_ready(col_ready8),
        .col_idx(col_idx), .col_last(col_last), .col_sel(col_sel), .col_val(col_val),
        .col_skip_zero(col_skip_zero), .out_valid(out_valid8), .out_ready(out_ready),
        .result(result8)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint scaled(input longint acc, input int sh);
        longint v;
        v = acc >>> sh;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (!start_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) chk("idle_timeout", 0, 1);
    endtask

    // a_mode 100 loads act[i] = i, otherwise every activation equals a_mode
    task automatic start_job(input int a_mode, input int sum_v, input longint init,
                             input int p, input bit sm, input longint exp, input bit push);
        wait_idle();
        for (int i = 0; i < 32; i++) act_in[i*8 +: 8] = 8'((a_mode == 100) ? i : a_mode);
        for (int g = 0; g < 4; g++) sum_act[g*11 +: 11] = 11'(sum_v);
        accum_init  = 24'(init);
        prec        = 4'(p);
        signed_mode = sm;
        start       = 1'b1;
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // sel_a >= 5 places out-of-window selects 5,6,7 rotating across slots
    task automatic beat(input int idx, input int sel_a, input bit val, input bit skip, input bit last);
        col_idx = 3'(idx);
        for (int s = 0; s < 16; s++) col_sel[s*3 +: 3] = (sel_a < 5) ? 3'(sel_a) : 3'(5 + s % 3);
        col_val       = val ? '1 : '0;
        col_skip_zero = skip ? '1 : '0;
        col_last      = last;
        col_valid     = 1'b1;
        chk("col_ready", col_ready, 1);
        @(posedge clk);
        @(negedge clk);
        col_valid = 1'b0;
        col_last  = 1'b0;
    endtask

    // Monitor: pops one expectation per presented result
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_acc = exp_q.pop_front();
                    for (int k = 0; k < hold_n; k++) begin
                        chk("hold_result", $signed(result), scaled(exp_acc, 0));
                        chk("hold_start_ready", start_ready, 0);
                        chk("hold_col_ready", col_ready, 0);
                        @(negedge clk);
                        chk("hold_valid", out_valid, 1);
                    end
                    hold_n = 0;
                    chk("result_sh0", $signed(result), scaled(exp_acc, 0));
                    chk("valid_sh8", out_valid8, 1);
                    chk("result_sh8", $signed(result8), scaled(exp_acc, 8));
                end
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
                chk("valid_drop", out_valid, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; act_in = '0; sum_act = '0; accum_init = '0;
        prec = '0; signed_mode = 1'b0; col_valid = 1'b0; col_idx = '0; col_last = 1'b0;
        col_sel = '0; col_val = '0; col_skip_zero = '0;
        repeat (2) @(negedge clk);
        chk("rst_start_ready", start_ready, 1);
        chk("rst_col_ready", col_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        reset = 1'b1;
        @(negedge clk);

        // single beat, latency check: valid low one edge after the beat, high the next
        start_job(1, 0, 0, 8, 0, 16, 1);
        beat(0, 0, 1, 1, 1);
        chk("lat_t0", out_valid, 0);
        @(negedge clk);
        chk("lat_t1", out_valid, 0);
        @(negedge clk);
        chk("lat_t2", out_valid, 1);

        // sum_act path with nothing selected, shifted by 2: 4*16 << 2
        start_job(2, 16, 0, 8, 0, 256, 1);
        beat(2, 0, 0, 0, 1);

        // signed MSB column negated: 16 - (16 << 3)
        start_job(1, 0, 0, 4, 1, -112, 1);
        beat(0, 0, 1, 1, 0);
        beat(3, 0, 1, 1, 1);

        // out-of-window selects add nothing; bubbles vs back-to-back: 16 + 0 + 32
        start_job(1, 0, 0, 8, 0, 48, 1);
        beat(0, 0, 1, 1, 0);
        beat(1, 5, 1, 1, 0);
        repeat (3) @(negedge clk);
        beat(1, 0, 1, 1, 1);
        start_job(1, 0, 0, 8, 0, 48, 1);
        beat(0, 0, 1, 1, 0);
        beat(1, 5, 1, 1, 0);
        beat(1, 0, 1, 1, 1);

        // act[i]=i, sel=4 reads act[g*8+j+4]: sum 32g+22 over g -> 280
        start_job(100, 0, 0, 8, 0, 280, 1);
        beat(0, 4, 1, 1, 1);
        // complement mode: sum_act 100 minus (32g+6) over g -> 184
        start_job(100, 100, 0, 8, 0, 184, 1);
        beat(0, 0, 1, 0, 1);
        // negative activations: -16 << 1
        start_job(-1, 0, 0, 8, 0, -32, 1);
        beat(1, 0, 1, 1, 1);
        // col_idx beyond prec is not negated: 16 << 3
        start_job(1, 0, 0, 2, 1, 128, 1);
        beat(3, 0, 1, 1, 1);

        // saturation and scaling through accum_init
        start_job(1, 0, 8388607, 8, 0, 8388607, 1);
        beat(0, 0, 0, 1, 1);
        start_job(1, 0, -8388608, 8, 0, -8388608, 1);
        beat(0, 0, 0, 1, 1);
        start_job(1, 0, 'h1200, 8, 0, 'h1200, 1);
        beat(0, 0, 0, 1, 1);

        // back-pressure in DONE with start/col_valid pulsed meanwhile
        wait_idle();
        hold_n = 5;
        start_job(1, 0, 0, 8, 0, 16, 1);
        beat(0, 0, 1, 1, 1);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; col_valid = 1'b1; col_last = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0; col_valid = 1'b0; col_last = 1'b0;

        // reset mid-RUN aborts silently; next job is clean
        start_job(1, 0, 100, 8, 0, 0, 0);
        beat(0, 0, 1, 1, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_start_ready", start_ready, 1);
        chk("abort_col_ready", col_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        start_job(1, 0, 0, 8, 0, 16, 1);
        beat(0, 0, 1, 1, 1);

        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        wait_idle();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_unit_bitcol_seq.md
Name: mac_unit_bitcol_seq

Overview:
Parametrised bit-column-serial MAC with an integrated column sequencer and valid/ready handshakes. It holds one activation vector and consumes one weight bit-column per accepted beat. Each beat selects activations through sparse window muxes and forms per-group partial sums, with optional complement-of-sum for zero-skipping. The partial sum is negated on the signed MSB column, shifted by column index and accumulated. It is the successor of the fixed 32-lane, fixed-8-bit PE: vector length, group size and max precision are generic, and per-job precision, signed/unsigned mode and a saturated, scaled result are added. It sits in the PE array between the column scheduler and the output collector.

Parameters:
DATA_WIDTH, 8, activation width (signed)
VEC_LENGTH, 32, activations per vector; multiple of GROUP_SIZE
GROUP_SIZE, 8, activations per group; even; GROUP_SIZE/2 mux slots per group
MUX_SEL_WIDTH, 3, mux select width; window = GROUP_SIZE/2+1 candidates
MAX_PREC, 8, max weight precision (columns); shift range 0..MAX_PREC-1
ACC_WIDTH, DATA_WIDTH+16, accumulator width
RESULT_WIDTH, 2*DATA_WIDTH, output width
OUT_SHIFT, 8, arithmetic right shift applied to accumulator before saturation

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
start  in  1  job request; sampled in IDLE only
start_ready  out  1  high in IDLE
act_in  in  VEC_LENGTH x DATA_WIDTH  activation vector, latched on start handshake
sum_act  in  (VEC_LENGTH/GROUP_SIZE) x SUM_W  per-group activation sums, SUM_W = DATA_WIDTH+clog2(GROUP_SIZE), latched on start
accum_init  in  ACC_WIDTH  initial accumulator value, latched on start
prec  in  clog2(MAX_PREC+1)  job precision 1..MAX_PREC, latched on start
signed_mode  in  1  weights two's-complement when 1; latched on start
col_valid  in  1  column beat valid
col_ready  out  1  high in RUN
col_idx  in  clog2(MAX_PREC)  bit position of this column
col_last  in  1  final column of job
col_sel  in  (VEC_LENGTH/2) x MUX_SEL_WIDTH  per-slot window select
col_val  in  VEC_LENGTH/2  per-slot valid
col_skip_zero  in  VEC_LENGTH/GROUP_SIZE  per-group: 1 = sum selected acts, 0 = sum_act minus selected sum
out_valid  out  1  result valid
out_ready  in  1  result accepted
result  out  RESULT_WIDTH  saturated scaled result

Behaviour:
- Reset (async assert): FSM=IDLE; accumulator, stage-1 register and latched job state cleared; out_valid=0, result=0, col_ready=0, start_ready=1 after release.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start&&start_ready latches act_in, sum_act, accum_init (into accumulator), prec, signed_mode, then goes to RUN.
- RUN: col_valid&&col_ready accepts a beat; col_last on an accepted beat goes to DRAIN. A job with zero columns is not supported; the scheduler always sends at least one.
- DRAIN: one cycle, then DONE. The last column reaches the accumulator on the same edge.
- DONE: out_valid=1 and result held stable until out_ready; then IDLE. start is ignored outside IDLE.
- Mux, slot s in group g (local j = s mod GROUP_SIZE/2): out = act[g*GROUP_SIZE + j + col_sel[s]] when col_val[s]=1 and col_sel[s] <= GROUP_SIZE/2; 0 otherwise. Indices never leave the group.
- Group partial sum P_g = sum of the group's slot outputs. T_g = P_g when col_skip_zero[g]=1, otherwise sum_act[g] - P_g. All arithmetic is signed and sign-extended, with no overflow at the parameter defaults.
- Column value C = sum over g of T_g. C is negated when signed_mode=1 and col_idx == prec-1.
- The result is shifted left by col_idx and sign-extended to ACC_WIDTH.
- Pipeline: stage-1 register captures the shifted C on an accepted beat. It holds a valid bit so bubbles (col_valid low) add nothing. The accumulator adds stage 1 on the next edge, modulo 2^ACC_WIDTH.
- Latency: a beat accepted at edge t is accumulated at edge t+1. If col_last is accepted at edge t, out_valid rises at edge t+2.
- col_idx >= prec: the beat is accepted and accumulated unchanged (scheduler error, not trapped).
- Output: result = saturate(accumulator >>> OUT_SHIFT) to [-2^(RESULT_WIDTH-1), 2^(RESULT_WIDTH-1)-1].
- Reset mid-job: immediate abort, nothing emitted.
- Columns may arrive in any order; each col_idx may repeat.

Test Plan:
- Defaults with OUT_SHIFT=0. act_in all 1, accum_init=0, prec=8, unsigned, one beat: col_idx=0, all sel=0, val=1, skip_zero=1, last -> result 16, out_valid 2 edges after beat.
- act_in all 2, sum_act=16 per group, one beat with all val=0, skip_zero=0, col_idx=2 -> C=64, result 256.
- Signed, prec=4, act all 1, beats col_idx 0 (all selected) and 3 (all selected, last) -> 16 - 128 = -112.
- sel=5..7 with val=1 on every slot -> contributes 0. Bubbles (col_valid low 3 cycles) between two beats -> same result as back-to-back.
- accum_init=2^23-1, OUT_SHIFT=0 -> result 32767. accum_init=-2^23 -> -32768. OUT_SHIFT=8 with accum_init=0x001200 -> 0x0012.
- Hold out_ready=0 for 5 cycles in DONE: result stable, start and col_valid ignored, then accept. Separately, reset=0 mid-RUN: out_valid=0, FSM IDLE, next job correct.
